// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared owner encoding, default widths and helpers for ram_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // Smallest r such that 2**r >= value (minimum 1 so counters never collapse)
    function automatic int ceil_log2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port valid/ready arbiter in front of one single-port ram,
//            round-robin with capped locked bursts; read data routed back by
//            a one-cycle rvalid pulse.
// Options  : RAM_ARB_FIXED_PRIO_EN - port A always wins contention
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic                  a_we_i,
    input  logic                  a_lock_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WORD_WIDTH-1:0] a_mask_i,
    input  logic [WORD_WIDTH-1:0] a_wdata_i,
    output logic [WORD_WIDTH-1:0] a_rdata_o,
    output logic                  a_rvalid_o,

    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic                  b_we_i,
    input  logic                  b_lock_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [WORD_WIDTH-1:0] b_mask_i,
    input  logic [WORD_WIDTH-1:0] b_wdata_i,
    output logic [WORD_WIDTH-1:0] b_rdata_o,
    output logic                  b_rvalid_o,

    output logic                  ram_clke_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_mask_o,
    output logic [WORD_WIDTH-1:0] ram_wdata_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

    localparam int                CNT_W = ceil_log2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             r_a_rvalid;
    logic             r_b_rvalid;

    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_cap_a;
    logic             w_cap_b;
    logic             w_tie_a;

    // ------------------------------------------------------------------------
    // Contention tie-break
    // ------------------------------------------------------------------------
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_tie_a = 1'b1;
`else
    logic r_rr_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_b <= 1'b0;
        end else if (w_gnt_a) begin
            r_rr_b <= 1'b1;
        end else if (w_gnt_b) begin
            r_rr_b <= 1'b0;
        end
    end

    assign w_tie_a = ~r_rr_b;
`endif

    // A capped owner yields as soon as the other side is waiting
    assign w_cap_a = (r_owner == OWN_A) && (r_cnt == C_MAX) && b_valid_i;
    assign w_cap_b = (r_owner == OWN_B) && (r_cnt == C_MAX) && a_valid_i;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (rst_i) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end else if (w_cap_a) begin
            w_gnt_b = 1'b1;
        end else if (w_cap_b) begin
            w_gnt_a = 1'b1;
        end else if (r_owner == OWN_A) begin
            w_gnt_a = a_valid_i;
        end else if (r_owner == OWN_B) begin
            w_gnt_b = b_valid_i;
        end else if (a_valid_i && b_valid_i) begin
            w_gnt_a = w_tie_a;
            w_gnt_b = ~w_tie_a;
        end else begin
            w_gnt_a = a_valid_i;
            w_gnt_b = b_valid_i;
        end
    end

    // ------------------------------------------------------------------------
    // Lock ownership state machine
    // ------------------------------------------------------------------------
    assign w_cnt_sat = (r_cnt == C_MAX) ? C_MAX : (r_cnt + C_ONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= OWN_NONE;
            r_cnt   <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (w_gnt_a) begin
            if (a_lock_i) begin
                w_owner_nxt = OWN_A;
                w_cnt_nxt   = (r_owner == OWN_A) ? w_cnt_sat : C_ONE;
            end else begin
                w_owner_nxt = OWN_NONE;
                w_cnt_nxt   = '0;
            end
        end else if (w_gnt_b) begin
            if (b_lock_i) begin
                w_owner_nxt = OWN_B;
                w_cnt_nxt   = (r_owner == OWN_B) ? w_cnt_sat : C_ONE;
            end else begin
                w_owner_nxt = OWN_NONE;
                w_cnt_nxt   = '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request mux towards the ram
    // ------------------------------------------------------------------------
    assign a_ready_o   = w_gnt_a;
    assign b_ready_o   = w_gnt_b;
    assign ram_clke_o  = w_gnt_a | w_gnt_b;
    assign ram_we_o    = w_gnt_b ? b_we_i : (w_gnt_a & a_we_i);
    assign ram_addr_o  = w_gnt_b ? b_addr_i  : a_addr_i;
    assign ram_mask_o  = w_gnt_b ? b_mask_i  : a_mask_i;
    assign ram_wdata_o = w_gnt_b ? b_wdata_i : a_wdata_i;

    // ------------------------------------------------------------------------
    // Read response steering
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_gnt_a & ~a_we_i;
            r_b_rvalid <= w_gnt_b & ~b_we_i;
        end
    end

    // Gated by reset so a response in flight is dropped in the reset cycle itself
    assign a_rvalid_o = r_a_rvalid & ~rst_i;
    assign b_rvalid_o = r_b_rvalid & ~rst_i;
    assign a_rdata_o  = ram_rdata_i;
    assign b_rdata_o  = ram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural ram and a
//            reference model of grants, lock bursts, memory and read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int WW = 16;
    localparam int AW = 9;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          a_valid = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [WW-1:0] a_mask = '0, a_wdata = '0;
    logic          b_valid = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [WW-1:0] b_mask = '0, b_wdata = '0;

    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [WW-1:0] a_rdata, b_rdata;
    logic          ram_clke, ram_we;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_mask, ram_wdata, ram_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_we_i      (a_we),
        .a_lock_i    (a_lock),
        .a_addr_i    (a_addr),
        .a_mask_i    (a_mask),
        .a_wdata_i   (a_wdata),
        .a_rdata_o   (a_rdata),
        .a_rvalid_o  (a_rvalid),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .b_we_i      (b_we),
        .b_lock_i    (b_lock),
        .b_addr_i    (b_addr),
        .b_mask_i    (b_mask),
        .b_wdata_i   (b_wdata),
        .b_rdata_o   (b_rdata),
        .b_rvalid_o  (b_rvalid),
        .ram_clke_o  (ram_clke),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_mask_o  (ram_mask),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    function automatic logic [WW-1:0] init_word(input int i);
        return WW'(i * 257) ^ 16'hA5C3;
    endfunction

    // Behavioural ram: registered read, masked write (mask bit 1 = keep)
    logic [WW-1:0] ram_mem [0:(1<<AW)-1];
    logic          ram_load = 1'b1;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= init_word(i);
        end else if (ram_clke) begin
            if (ram_we) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ram_mask) | (ram_wdata & ~ram_mask);
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    logic [WW-1:0] m_mem [0:(1<<AW)-1];
    int            m_lock;      // 0 none, 1 A, 2 B
    int            m_beats;
    int            m_pref;      // port that wins the next tie
    int            m_pend;      // port owed a read response this cycle
    logic [WW-1:0] m_pend_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic req_a(input logic we, input logic lk, input logic [AW-1:0] ad,
                         input logic [WW-1:0] mk, input logic [WW-1:0] wd);
        a_valid = 1'b1; a_we = we; a_lock = lk; a_addr = ad; a_mask = mk; a_wdata = wd;
    endtask

    task automatic req_b(input logic we, input logic lk, input logic [AW-1:0] ad,
                         input logic [WW-1:0] mk, input logic [WW-1:0] wd);
        b_valid = 1'b1; b_we = we; b_lock = lk; b_addr = ad; b_mask = mk; b_wdata = wd;
    endtask

    // One clock: check outputs against the model, clock, advance the model
    task automatic step(output bit acc_a, output bit acc_b);
        int            w;
        logic          we, lk;
        logic [AW-1:0] ad;
        logic [WW-1:0] mk, wd;
        #1;
        w = 0;
        if (rst)                                           w = 0;
        else if (m_lock == 1 && m_beats >= MB && b_valid)  w = 2;
        else if (m_lock == 2 && m_beats >= MB && a_valid)  w = 1;
        else if (m_lock == 1)                              w = a_valid ? 1 : 0;
        else if (m_lock == 2)                              w = b_valid ? 2 : 0;
        else if (a_valid && b_valid)                       w = m_pref;
        else if (a_valid)                                  w = 1;
        else if (b_valid)                                  w = 2;

        we = (w == 2) ? b_we    : a_we;
        lk = (w == 2) ? b_lock  : a_lock;
        ad = (w == 2) ? b_addr  : a_addr;
        mk = (w == 2) ? b_mask  : a_mask;
        wd = (w == 2) ? b_wdata : a_wdata;

        chk("a_ready", 32'(a_ready), 32'(w == 1));
        chk("b_ready", 32'(b_ready), 32'(w == 2));
        chk("ram_clke", 32'(ram_clke), 32'(w != 0));
        chk("ram_we", 32'(ram_we), 32'((w != 0) && we));
        if (w != 0) begin
            chk("ram_addr", 32'(ram_addr), 32'(ad));
            if (we) begin
                chk("ram_mask", 32'(ram_mask), 32'(mk));
                chk("ram_wdata", 32'(ram_wdata), 32'(wd));
            end
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(!rst && m_pend == 1));
        chk("b_rvalid", 32'(b_rvalid), 32'(!rst && m_pend == 2));
        if (!rst && m_pend == 1) chk("a_rdata", 32'(a_rdata), 32'(m_pend_data));
        if (!rst && m_pend == 2) chk("b_rdata", 32'(b_rdata), 32'(m_pend_data));

        acc_a = (w == 1);
        acc_b = (w == 2);
        @(posedge clk);

        if (rst) begin
            m_lock = 0; m_beats = 0; m_pend = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
            m_pref = 1;
`else
            m_pref = 1;
`endif
        end else begin
            m_pend = 0;
            if (w != 0) begin
                if (we) begin
                    m_mem[ad] = (m_mem[ad] & mk) | (wd & ~mk);
                end else begin
                    m_pend      = w;
                    m_pend_data = m_mem[ad];
                end
                if (lk) begin
                    if (m_lock == w) begin
                        if (m_beats < MB) m_beats++;
                    end else begin
                        m_beats = 1;
                    end
                    m_lock = w;
                end else begin
                    m_lock  = 0;
                    m_beats = 0;
                end
`ifdef RAM_ARB_FIXED_PRIO_EN
                m_pref = 1;
`else
                m_pref = 3 - w;
`endif
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit            acc_a, acc_b;
        int            cnt_a, a_beats, cyc;
        int            seq[$];
        logic [WW-1:0] w0;

        for (int i = 0; i < (1 << AW); i++) m_mem[i] = init_word(i);
        m_lock = 0; m_beats = 0; m_pref = 1; m_pend = 0; m_pend_data = '0;

        @(negedge clk);
        @(negedge clk);
        ram_load = 1'b0;
        // Reset state, with a request present that must not be granted
        req_a(1'b0, 1'b0, 9'h001, '0, '0);
        step(acc_a, acc_b);
        a_valid = 1'b0;
        rst = 1'b0;
        step(acc_a, acc_b);

        // Single A read
        req_a(1'b0, 1'b0, 9'h005, '0, '0);
        step(acc_a, acc_b);
        chk("t1_accept", 32'(acc_a), 32'd1);
        a_valid = 1'b0;
        #1;
        chk("t1_rvalid", 32'(a_rvalid), 32'd1);
        chk("t1_rdata", 32'(a_rdata), 32'(init_word(5)));
        chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
        step(acc_a, acc_b);

        // Masked write from A, read back from B
        req_a(1'b1, 1'b0, 9'h010, 16'h00FF, 16'h1234);
        step(acc_a, acc_b);
        a_valid = 1'b0;
        req_b(1'b0, 1'b0, 9'h010, '0, '0);
        step(acc_a, acc_b);
        b_valid = 1'b0;
        #1;
        w0 = init_word(16);
        chk("t2_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("t2_b_rdata", 32'(b_rdata), 32'({8'h12, w0[7:0]}));
        step(acc_a, acc_b);

        // Six cycles of contention without lock
        cnt_a = 0;
        req_a(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
        req_b(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
        for (int c = 0; c < 6; c++) begin
            step(acc_a, acc_b);
            if (acc_a) begin
                cnt_a++;
                req_a(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
            end
            if (acc_b) req_b(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("t3_a_grants", 32'(cnt_a), 32'd6);
`else
        chk("t3_a_grants", 32'(cnt_a), 32'd3);
`endif

        // Locked 12-beat A burst against a continuously valid B
        a_beats = 0;
        cyc     = 0;
        req_a(1'b1, 1'b1, 9'h040, 16'h0000, 16'($urandom));
        req_b(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
        while (a_beats < 12 && cyc < 40) begin
            step(acc_a, acc_b);
            cyc++;
            if (acc_a) begin
                seq.push_back(1);
                a_beats++;
                req_a(1'b1, 1'(a_beats < 11), 9'(9'h040 + a_beats), 16'h0000, 16'($urandom));
            end
            if (acc_b) begin
                seq.push_back(2);
                req_b(1'b0, 1'b0, 9'($urandom_range(31)), '0, '0);
            end
        end
        chk("t4_done", 32'(a_beats), 32'd12);
        while (seq.size() < 10) seq.push_back(0);
        for (int i = 0; i < MB; i++) chk("t4_a_beat", 32'(seq[i]), 32'd1);
        chk("t4_b_slot", 32'(seq[MB]), 32'd2);
        chk("t4_a_resume", 32'(seq[MB+1]), 32'd1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step(acc_a, acc_b);

        // Reset right after an accepted read
        req_a(1'b0, 1'b0, 9'h007, '0, '0);
        step(acc_a, acc_b);
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rvalid_dropped", 32'(a_rvalid), 32'd0);
        step(acc_a, acc_b);
        rst = 1'b0;
        req_a(1'b0, 1'b0, 9'h003, '0, '0);
        req_b(1'b0, 1'b0, 9'h004, '0, '0);
        step(acc_a, acc_b);
        chk("t5_a_first", 32'(acc_a), 32'd1);
        if (acc_b) b_valid = 1'b0;
        a_valid = 1'b0;

        // Randomised traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if (!a_valid || acc_a) begin
                if ($urandom_range(9) < 6)
                    req_a(1'($urandom_range(1)), 1'($urandom_range(1)), 9'($urandom_range(31)),
                          16'($urandom), 16'($urandom));
                else
                    a_valid = 1'b0;
            end
            if (!b_valid || acc_b) begin
                if ($urandom_range(9) < 6)
                    req_b(1'($urandom_range(1)), 1'($urandom_range(1)), 9'($urandom_range(31)),
                          16'($urandom), 16'($urandom));
                else
                    b_valid = 1'b0;
            end
            rst = ($urandom_range(249) == 0);
            step(acc_a, acc_b);
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step(acc_a, acc_b);
        step(acc_a, acc_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
